win_checker: RTL and testbench



---
 rtl/ttt_pkg.sv | 70 +++++++
 rtl/ttt_line_match.sv | 17 +
 rtl/win_checker.sv | 94 +++++++++
 tb/tb_win_checker.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board evaluator: cell codes, line table,
// win_case field layout and FSM states.
package ttt_pkg;

   localparam int unsigned CELL_W  = 2;
   localparam int unsigned N_CELLS = 9;
   localparam int unsigned N_LINES = 8;
   localparam int unsigned CIDX_W  = 4;
   localparam int unsigned LINE_W  = 3;
   localparam int unsigned WC_W    = 6;

   localparam logic [CELL_W-1:0] EMPTY  = 2'b00;
   localparam logic [CELL_W-1:0] X_CODE = 2'b01;
   localparam logic [CELL_W-1:0] O_CODE = 2'b10;
   localparam logic [CELL_W-1:0] BOTH   = 2'b11;

   localparam int unsigned GAME_OVER = 5;
   localparam int unsigned WIN       = 4;
   localparam int unsigned WINNER_X  = 3;
   localparam int unsigned LINE_LSB  = 0;

   typedef logic [N_CELLS-1:0][CELL_W-1:0] board_t;
   typedef logic [LINE_W-1:0]              line_idx_t;
   typedef logic [WC_W-1:0]                win_case_t;

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   // Cells making up each line, in scan (priority) order.
   localparam logic [CIDX_W-1:0] LINE_CELLS [N_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   function automatic win_case_t win_code(input logic x_won, input line_idx_t idx);
      win_case_t wc;
      wc                     = '0;
      wc[GAME_OVER]          = 1'b1;
      wc[WIN]                = 1'b1;
      wc[WINNER_X]           = x_won;
      wc[LINE_LSB +: LINE_W] = idx;
      return wc;
   endfunction

   function automatic win_case_t tie_code();
      win_case_t wc;
      wc            = '0;
      wc[GAME_OVER] = 1'b1;
      return wc;
   endfunction

   // A board is full only when every cell is a real X or O mark.
   function automatic logic board_full(input board_t b);
      logic full;
      full = 1'b1;
      for (int i = 0; i < int'(N_CELLS); i++) begin
         if (b[i] != X_CODE && b[i] != O_CODE) full = 1'b0;
      end
      return full;
   endfunction

endpackage

// File: rtl/ttt_line_match.sv
// Tests one three-cell line for a complete X or O.
module ttt_line_match
   import ttt_pkg::*;
(
   input  logic [CELL_W-1:0] c0,
   input  logic [CELL_W-1:0] c1,
   input  logic [CELL_W-1:0] c2,
   output logic              x_match,
   output logic              o_match
);

   always_comb begin
      x_match = (c0 == X_CODE) && (c1 == X_CODE) && (c2 == X_CODE);
      o_match = (c0 == O_CODE) && (c1 == O_CODE) && (c2 == O_CODE);
   end

endmodule

// File: rtl/win_checker.sv
// Sequential 3x3 board evaluator: snapshots the board on start, scans one line per
// clock and reports win/tie/none on win_case with a one-cycle done pulse.
module win_checker
   import ttt_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             clear,
   input  logic [N_CELLS-1:0][CELL_W-1:0]   main_vector,
   output logic                             busy,
   output logic                             done,
   output logic [WC_W-1:0]                  win_case
);

   state_t    state_q, state_d;
   line_idx_t idx_q, idx_d;
   board_t    snap_q, snap_d;
   logic      busy_d, done_d;
   win_case_t win_case_d;
   logic      x_match, o_match;

   ttt_line_match u_line_match (
      .c0      (snap_q[LINE_CELLS[idx_q][0]]),
      .c1      (snap_q[LINE_CELLS[idx_q][1]]),
      .c2      (snap_q[LINE_CELLS[idx_q][2]]),
      .x_match (x_match),
      .o_match (o_match)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         snap_q   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         win_case <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         snap_q   <= snap_d;
         busy     <= busy_d;
         done     <= done_d;
         win_case <= win_case_d;
      end
   end

   // Next state; clear overrides both a new start and a pending scan result.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      snap_d     = snap_q;
      busy_d     = busy;
      done_d     = 1'b0;
      win_case_d = win_case;

      if (clear) begin
         state_d    = IDLE;
         idx_d      = '0;
         busy_d     = 1'b0;
         win_case_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // A start seen while done is still showing belongs to the finished scan.
               if (start && !done) begin
                  snap_d  = main_vector;
                  idx_d   = '0;
                  busy_d  = 1'b1;
                  state_d = SCAN;
               end
            end
            SCAN: begin
               if (x_match || o_match) begin
                  win_case_d = win_code(x_match, idx_q);
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = IDLE;
               end else if (idx_q == LINE_W'(N_LINES - 1)) begin
                  win_case_d = board_full(snap_q) ? tie_code() : '0;
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = IDLE;
               end else begin
                  idx_d = idx_q + LINE_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_win_checker.sv
// Self-checking bench for win_checker: a reference model queues expected win_case
// codes and a monitor pops them on every done pulse.
module tb_win_checker;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             clear;
   logic [8:0][1:0]  main_vector;
   logic             busy;
   logic             done;
   logic [5:0]       win_case;

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_done = 0;

   logic [5:0] exp_q[$];
   logic [5:0] mon_exp;

   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   win_checker dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .clear       (clear),
      .main_vector (main_vector),
      .busy        (busy),
      .done        (done),
      .win_case    (win_case)
   );

   always #5 clk = ~clk;

   // Scoreboard: every done must match the oldest queued expectation.
   always @(posedge clk) begin
      #2;
      if (done === 1'b1) begin
         n_done++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_done: win_case=%b, required no done pulse", win_case);
         end else begin
            mon_exp = exp_q.pop_front();
            if (win_case !== mon_exp) begin
               n_bad++;
               $display("FAIL win_case: got %b required %b", win_case, mon_exp);
            end
         end
      end
   end

   // Reference: first matching line wins (X before O), else tie/none on a full board.
   function automatic void model(input logic [8:0][1:0] b, output logic [5:0] wc, output int lat);
      bit full;
      wc  = 6'b000000;
      lat = 8;
      for (int i = 0; i < 8; i++) begin
         if (b[lines[i][0]] == 2'b01 && b[lines[i][1]] == 2'b01 && b[lines[i][2]] == 2'b01) begin
            wc  = {3'b111, 3'(i)};
            lat = i + 1;
            return;
         end
         if (b[lines[i][0]] == 2'b10 && b[lines[i][1]] == 2'b10 && b[lines[i][2]] == 2'b10) begin
            wc  = {3'b110, 3'(i)};
            lat = i + 1;
            return;
         end
      end
      full = 1'b1;
      for (int c = 0; c < 9; c++) begin
         if (b[c] != 2'b01 && b[c] != 2'b10) full = 1'b0;
      end
      wc = full ? 6'b100000 : 6'b000000;
   endfunction

   function automatic logic [8:0][1:0] mk(input string s);
      logic [8:0][1:0] b;
      for (int c = 0; c < 9; c++) begin
         case (s[c])
            "X":     b[c] = 2'b01;
            "O":     b[c] = 2'b10;
            "B":     b[c] = 2'b11;
            default: b[c] = 2'b00;
         endcase
      end
      return b;
   endfunction

   // Waits (bounded) for done after n0 cycles already spent in SCAN; checks latency and pulse shape.
   task automatic wait_done(input string name, input int lat, input int n0);
      int n;
      bit seen;
      seen = 1'b0;
      for (n = n0 + 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!seen || n != lat) begin
         n_bad++;
         $display("FAIL %s_latency: seen=%0d cycles=%0d required %0d", name, seen, n, lat);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_busy_at_done: busy=%b required 0", name, busy);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_done_width: done=%b required 0", name, done);
      end
   endtask

   task automatic run_eval(input string name, input logic [8:0][1:0] b);
      logic [5:0] wc;
      int lat;
      model(b, wc, lat);
      exp_q.push_back(wc);
      main_vector = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_busy_rise: busy=%b required 1", name, busy);
      end
      wait_done(name, lat, 0);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; clear = 1'b0; main_vector = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, win_case} !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_outputs: busy=%b done=%b win_case=%b required 0/0/000000", busy, done, win_case);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, win_case} !== 8'h00) begin
         n_bad++;
         $display("FAIL idle_after_reset: busy=%b done=%b win_case=%b required 0/0/000000", busy, done, win_case);
      end
   endtask

   task automatic test_row0_x();
      run_eval("row0_x", mk("XXX______"));
   endtask

   task automatic test_diag_o();
      run_eval("diag_o", mk("XXOXOXO__"));
   endtask

   task automatic test_tie();
      run_eval("tie", mk("XOXXOOOXX"));
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (win_case !== 6'b100000) begin
         n_bad++;
         $display("FAIL tie_hold: win_case=%b required 100000", win_case);
      end
      run_eval("no_result", mk("XOXXOOOX_"));
      run_eval("both_cell", mk("XOXXOOOXB"));
   endtask

   task automatic test_back_to_back();
      logic [5:0] wc;
      int lat;
      int d0;
      d0 = n_done;
      model(mk("XXOXOXO__"), wc, lat);
      exp_q.push_back(wc);
      main_vector = mk("XXOXOXO__");
      start = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      start = 1'b0;
      main_vector = mk("___XXX___");
      wait_done("b2b", lat, 2);
      repeat (12) @(posedge clk);
      #3;
      n_cmp++;
      if (n_done - d0 != 1) begin
         n_bad++;
         $display("FAIL b2b_done_count: got %0d done pulses required 1", n_done - d0);
      end
   endtask

   task automatic test_clear();
      int d0;
      d0 = n_done;
      main_vector = mk("XOXXOOOX_");
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      n_cmp++;
      if ({busy, done, win_case} !== 8'h00) begin
         n_bad++;
         $display("FAIL clear_outputs: busy=%b done=%b win_case=%b required 0/0/000000", busy, done, win_case);
      end
      repeat (12) @(posedge clk);
      #3;
      n_cmp++;
      if (n_done != d0) begin
         n_bad++;
         $display("FAIL clear_no_done: got %0d done pulses required 0", n_done - d0);
      end
   endtask

   task automatic test_rst_mid();
      int d0;
      run_eval("pre_rst", mk("XXX______"));
      d0 = n_done;
      main_vector = mk("XOXXOOOX_");
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      #3;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, win_case} !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_async: busy=%b done=%b win_case=%b required 0/0/000000", busy, done, win_case);
      end
      #2;
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #3;
      n_cmp++;
      if (n_done != d0) begin
         n_bad++;
         $display("FAIL rst_no_done: got %0d done pulses required 0", n_done - d0);
      end
   endtask

   task automatic test_illegal();
      run_eval("illegal_two_wins", mk("___OOOXXX"));
      run_eval("col1_x", mk("_X__X__X_"));
   endtask

   initial begin
      test_reset();
      test_row0_x();
      test_diag_o();
      test_tie();
      test_back_to_back();
      test_clear();
      test_rst_mid();
      test_illegal();
      repeat (2) @(posedge clk);
      #3;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_done: %0d expected results never produced, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
